// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// result-source codes and the memory-wait FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one E-stage source register; the M-stage
// producer has priority over the W-stage producer, and x0 never forwards.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
            sel = FWD_M;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// generation, E-stage forwarding, memory-wait/timeout FSM and perf counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       mem_wait;
    logic       load_use;
    logic       in_err;
    logic       branch_flush;
    logic [1:0] fwd_a, fwd_b;

    forward_sel u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .sel       (fwd_a)
    );

    forward_sel u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .sel       (fwd_b)
    );

    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    assign mem_wait = MemReqM && !MemReadyM;
    assign load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign in_err   = (state_q == ST_ERR);

    // Priority: ERR > memory wait > taken branch > load-use.
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushW       = 1'b0;
        branch_flush = 1'b0;
        if (!rst) begin
            if (in_err || mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD       = 1'b1;
                FlushE       = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // WAIT only tracks the timeout; the stall itself comes from mem_wait.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err      = in_err;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized bench for hazard_controller, checked every cycle
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_controller;

    localparam int MEM_TO = 4;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    // model state
    int run_len;
    bit err_m;
    int sc, fe;

    hazard_controller #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Check one cycle against the model, advance the model, move past the edge.
    task automatic step();
        bit mw, hold, br, lu, eF;
        @(negedge clk);
        mw   = MemReqM && !MemReadyM;
        hold = !rst && (err_m || mw);
        br   = !rst && !hold && PCSrcE;
        lu   = !rst && !hold && !br && ResultSrcE == 2'b01 && RdE != 0 &&
               (RdE == Rs1D || RdE == Rs2D);
        eF   = hold || lu;
        check("StallF", 16'(StallF), 16'(eF));
        check("StallD", 16'(StallD), 16'(eF));
        check("StallE", 16'(StallE), 16'(hold));
        check("StallM", 16'(StallM), 16'(hold));
        check("FlushD", 16'(FlushD), 16'(br));
        check("FlushE", 16'(FlushE), 16'(br || lu));
        check("FlushW", 16'(FlushW), 16'(hold));
        check("ForwardAE", 16'(ForwardAE), 16'(fwd_exp(Rs1E)));
        check("ForwardBE", 16'(ForwardBE), 16'(fwd_exp(Rs2E)));
        check("mem_err", 16'(mem_err), 16'(err_m));
        check("stall_cycles", 16'(stall_cycles), 16'(sc));
        check("flush_events", 16'(flush_events), 16'(fe));
        if (rst) begin
            run_len = 0; err_m = 0; sc = 0; fe = 0;
        end else begin
            if (eF && sc < MAXC) sc++;
            if (br && fe < MAXC) fe++;
            if (!err_m) begin
                // error once the memory has stalled MEM_TO consecutive cycles
                if (mw) begin
                    run_len++;
                    if (run_len >= MEM_TO) err_m = 1;
                end else begin
                    run_len = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_len = 0; err_m = 0; sc = 0; fe = 0;

        // reset suppresses outputs even with active hazards
        PCSrcE = 1; MemReqM = 1; RegWriteM = 1; RdM = 3; Rs1E = 3;
        step();
        do_reset();

        // forwarding priority
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        step();
        check("fwdA_M", 16'(ForwardAE), 16'(2'b10));
        RdM = 0;
        step();
        check("fwdA_W", 16'(ForwardAE), 16'(2'b01));
        RdW = 0;
        step();
        check("fwdB_RF", 16'(ForwardBE), 16'(2'b00));

        // load-use
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        step();
        idle_inputs();
        step();
        check("lu_stall_cnt", 16'(stall_cycles), 16'd1);

        // branch beats load-use
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
        step();
        idle_inputs();
        step();
        check("br_flush_cnt", 16'(flush_events), 16'd1);
        check("br_stall_cnt", 16'(stall_cycles), 16'd0);

        // memory wait, branch held off until release
        do_reset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        repeat (3) step();
        check("mw_flush_cnt", 16'(flush_events), 16'd0);
        MemReadyM = 1;
        step();
        check("mw_stall_cnt", 16'(stall_cycles), 16'd3);
        idle_inputs();
        step();

        // timeout into sticky error
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        repeat (5) step();
        check("to_mem_err", 16'(mem_err), 16'd1);
        idle_inputs();
        PCSrcE = 1;
        repeat (2) step();
        check("err_held", 16'(StallM), 16'd1);
        do_reset();
        step();
        check("err_cleared", 16'(mem_err), 16'd0);

        // counter saturation
        do_reset();
        ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
        repeat (20) step();
        check("sat_stall", 16'(stall_cycles), 16'd15);
        step();
        check("sat_stay", 16'(stall_cycles), 16'd15);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) MemReqM = ~MemReqM;
            MemReadyM  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
